// File: rtl/core_alu_pkg.sv
// ---------------------------------------------------------------------------
// core_alu_pkg
// Shared types for the execute-stage ALU and its two-requester arbiter.
//   alu_op_t     : 5-bit ALU operation code (OP/OP-IMM, branch compares,
//                  load/store address add)
//   arb_state_t  : sequencing states of core_alu_arb
//   XLEN_DEFAULT : default datapath width
//   ALU_OP_W     : width of alu_op_t
// ---------------------------------------------------------------------------
package core_alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ALU_OP_W     = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD     = 5'd0,
        ALU_SUB     = 5'd1,
        ALU_SLL     = 5'd2,
        ALU_SLT     = 5'd3,
        ALU_SLTU    = 5'd4,
        ALU_XOR     = 5'd5,
        ALU_SRL     = 5'd6,
        ALU_SRA     = 5'd7,
        ALU_OR      = 5'd8,
        ALU_AND     = 5'd9,
        ALU_BEQ     = 5'd10,
        ALU_BNE     = 5'd11,
        ALU_BLT     = 5'd12,
        ALU_BGE     = 5'd13,
        ALU_BLTU    = 5'd14,
        ALU_BGEU    = 5'd15,
        ALU_LSU_ADD = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/core_alu_arb_grant.sv
// ---------------------------------------------------------------------------
// core_alu_arb_grant
// Two-way grant logic for core_alu_arb.
//
// Build option (macro CORE_ALU_ARB_RR_EN):
//   defined   : round-robin; a one-bit pointer names the requester that wins
//               a tie, and it moves to the non-owner after every completed
//               response handshake.
//   undefined : fixed priority, requester 0 always wins; no pointer flop and
//               no clock/reset ports.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset (RR build only)
//   done        : response handshake completed this cycle (RR build only)
//   done_owner  : requester that owned the completed operation (RR build only)
//   req_valid   : {req1_valid, req0_valid}
//   grant       : one-hot (or zero) winner among the valid requesters
// ---------------------------------------------------------------------------
module core_alu_arb_grant
    import core_alu_pkg::*;
(
`ifdef CORE_ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       done_owner,
`endif
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

`ifdef CORE_ALU_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    // After each finished operation the pointer moves to whoever did not
    // own it, so a requester that just lost a tie wins the next one.
    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = ~done_owner;
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // A lone requester always wins; a tie goes to the pointed-to requester.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end
`else
    // Fixed priority: requester 1 is granted only when requester 0 is idle.
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/core_alu_arb.sv
// ---------------------------------------------------------------------------
// core_alu_arb
// Arbiter/sequencer in front of the shared, clocked core_alu. Accepts one
// operation at a time from requester 0 (integer execute) or requester 1
// (load/store address generation), pulses alu_start once with stable
// operands, waits ALU_LAT cycles, captures alu_result and hands it back to
// the owning requester.
//
// Build option: CORE_ALU_ARB_RR_EN selects round-robin arbitration (see
// core_alu_arb_grant); undefined gives fixed priority to requester 0.
//
// Parameters:
//   XLEN    : datapath width
//   OP_W    : ALU op code width
//   ALU_LAT : cycles from alu_start to a valid alu_result (>= 1)
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   reqN_valid/reqN_ready            : request handshake (ready is
//                                      combinational, IDLE only)
//   reqN_op, reqN_rs1/rs2/imm        : operation and operands
//   rspN_valid/rspN_ready            : response handshake to the owner
//   rspN_result                      : shared result register
//   alu_start                        : one-cycle issue pulse
//   alu_op, alu_rs1/rs2/imm          : latched operands held for the ALU
//   alu_result                       : ALU output
// ---------------------------------------------------------------------------
module core_alu_arb
    import core_alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int OP_W    = ALU_OP_W,
    parameter int ALU_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [XLEN-1:0] req0_imm,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [XLEN-1:0] req1_imm,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic            alu_start,
    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [XLEN-1:0] alu_imm,
    input  logic [XLEN-1:0] alu_result
);

    // A zero-latency ALU cannot be sequenced by this block.
    if (ALU_LAT < 1) begin : g_lat_check
        $error("core_alu_arb: ALU_LAT must be at least 1");
    end

    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    arb_state_t      state_q,     state_d;
    logic            owner_q,     owner_d;
    logic [OP_W-1:0] op_q,        op_d;
    logic [XLEN-1:0] rs1_q,       rs1_d;
    logic [XLEN-1:0] rs2_q,       rs2_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic            alu_start_q, alu_start_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;

    logic [1:0]      grant;
    logic [1:0]      req_ready;
    logic            rsp_hs;

    core_alu_arb_grant u_grant (
`ifdef CORE_ALU_ARB_RR_EN
        .clk        (clk),
        .rst        (rst),
        .done       (rsp_hs),
        .done_owner (owner_q),
`endif
        .req_valid  ({req1_valid, req0_valid}),
        .grant      (grant)
    );

    // Only an idle block offers ready, and only to the arbitration winner.
    assign req_ready  = (state_q == ST_IDLE) ? grant : 2'b00;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // rsp_valid_q is non-zero only in RESP, so this is the owner's handshake.
    assign rsp_hs = (rsp_valid_q[0] & rsp0_ready) | (rsp_valid_q[1] & rsp1_ready);

    // Sequencing: latch the winner's operation, pulse start, count out the
    // ALU latency, capture the result, then hold it until the owner takes it.
    // alu_start and rsp_valid are computed one state ahead so they come
    // straight out of flops.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        alu_start_d = 1'b0;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (req_ready[1]) begin
                    owner_d     = 1'b1;
                    op_d        = req1_op;
                    rs1_d       = req1_rs1;
                    rs2_d       = req1_rs2;
                    imm_d       = req1_imm;
                    alu_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (req_ready[0]) begin
                    owner_d     = 1'b0;
                    op_d        = req0_op;
                    rs1_d       = req0_rs1;
                    rs2_d       = req0_rs2;
                    imm_d       = req0_imm;
                    alu_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The counter cannot overflow: its width holds ALU_LAT.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d    = alu_result;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and registered outputs. Reset abandons any operation in
    // flight; whatever the ALU produces later is never sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            alu_start_q <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            alu_start_q <= alu_start_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_start   = alu_start_q;
    assign alu_op      = op_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign alu_imm     = imm_q;
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;

endmodule

// File: tb/tb_core_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_core_alu_arb
// Self-checking bench for core_alu_arb with a behavioural clocked ALU.
// Expected responses are queued when an operation is accepted and checked
// by a monitor whenever a response is presented. Honours CORE_ALU_ARB_RR_EN
// for the arbitration expectations.
// ---------------------------------------------------------------------------
module tb_core_alu_arb;
    import core_alu_pkg::*;

    localparam int XLEN    = 32;
    localparam int ALU_LAT = 2;

    logic            clk;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]      req0_op, req1_op;
    logic [XLEN-1:0] req0_rs1, req0_rs2, req0_imm;
    logic [XLEN-1:0] req1_rs1, req1_rs2, req1_imm;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp0_result, rsp1_result;
    logic            alu_start;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] alu_rs1, alu_rs2, alu_imm, alu_result;

    core_alu_arb #(.XLEN(XLEN), .OP_W(5), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_start(alu_start), .alu_op(alu_op), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_result(alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the ALU computes for each op code.
    function automatic logic [XLEN-1:0] alu_ref(input logic [4:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm);
        case (alu_op_t'(op))
            ALU_ADD:     return a + b;
            ALU_SUB:     return a - b;
            ALU_SLL:     return a << b[4:0];
            ALU_SLT:     return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:    return {31'd0, a < b};
            ALU_XOR:     return a ^ b;
            ALU_SRL:     return a >> b[4:0];
            ALU_SRA:     return $signed(a) >>> b[4:0];
            ALU_OR:      return a | b;
            ALU_AND:     return a & b;
            ALU_BEQ:     return {31'd0, a == b};
            ALU_BNE:     return {31'd0, a != b};
            ALU_BLT:     return {31'd0, $signed(a) < $signed(b)};
            ALU_BGE:     return {31'd0, $signed(a) >= $signed(b)};
            ALU_BLTU:    return {31'd0, a < b};
            ALU_BGEU:    return {31'd0, a >= b};
            ALU_LSU_ADD: return a + imm;
            default:     return '0;
        endcase
    endfunction

    // Clocked ALU: result valid exactly ALU_LAT cycles after alu_start,
    // noise at every other time so a mistimed capture is visible.
    logic [XLEN-1:0] pipe_d [ALU_LAT];
    logic            pipe_v [ALU_LAT];
    logic [XLEN-1:0] alu_noise;

    always @(posedge clk) begin
        alu_noise <= $urandom;
        pipe_v[0] <= alu_start;
        pipe_d[0] <= alu_ref(alu_op, alu_rs1, alu_rs2, alu_imm);
        for (int i = 1; i < ALU_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign alu_result = pipe_v[ALU_LAT-1] ? pipe_d[ALU_LAT-1] : alu_noise;

    // Arbitration rule: lone requester wins; ties go to the pointer (RR)
    // or to requester 0 (fixed priority).
    function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) begin
`ifdef CORE_ALU_ARB_RR_EN
            return ptr ? 2'b10 : 2'b01;
`else
            return (ptr == ptr) ? 2'b01 : 2'b01;
`endif
        end
        if (v0) return 2'b01;
        if (v1) return 2'b10;
        return 2'b00;
    endfunction

    typedef struct {
        logic            owner;
        logic [4:0]      op;
        logic [XLEN-1:0] rs1, rs2, imm, res;
    } sb_t;

    sb_t sb[$];

    // Monitor: cycle offset since acceptance (-1 when idle) drives all
    // expectations; a response is checked against the queue head while
    // presented and popped on its handshake.
    int         phase   = -1;
    logic       owner_m = 1'b0;
    logic       ptr_m   = 1'b0;
    logic       fresh_m = 1'b0;
    logic       live    = 1'b0;
    logic       prev_rst = 1'b0, prev_acc = 1'b0, prev_acc_owner = 1'b0, prev_rsp_hs = 1'b0;

    always @(negedge clk) begin
        logic [1:0] exp_g;
        logic [1:0] exp_rv;
        sb_t        e;

        if (prev_rst) begin
            phase = -1; sb.delete(); ptr_m = 1'b0; fresh_m = 1'b1; live = 1'b1;
        end else if (live) begin
            if (phase < 0) begin
                if (prev_acc) begin
                    phase = 1; owner_m = prev_acc_owner; fresh_m = 1'b0;
                end
            end else if (prev_rsp_hs) begin
                phase = -1; ptr_m = ~owner_m;
                if (sb.size() > 0) void'(sb.pop_front());
            end else begin
                phase++;
            end
        end

        prev_acc    = 1'b0;
        prev_rsp_hs = 1'b0;
        if (live) begin
            exp_g = (phase < 0) ? exp_grant(req0_valid, req1_valid, ptr_m) : 2'b00;
            checkOutput("req_ready", {req1_ready, req0_ready}, exp_g);
            checkOutput("alu_start", alu_start, phase == 1);
            exp_rv = (phase >= ALU_LAT + 2) ? (owner_m ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("rsp_valid", {rsp1_valid, rsp0_valid}, exp_rv);
            if (phase >= 1 && phase <= ALU_LAT + 1 && sb.size() > 0) begin
                checkOutput("alu_op",  alu_op,  sb[0].op);
                checkOutput("alu_rs1", alu_rs1, sb[0].rs1);
                checkOutput("alu_rs2", alu_rs2, sb[0].rs2);
                checkOutput("alu_imm", alu_imm, sb[0].imm);
            end
            if (phase >= ALU_LAT + 2 && sb.size() > 0) begin
                checkOutput("rsp_result", owner_m ? rsp1_result : rsp0_result, sb[0].res);
            end
            if (phase < 0 && fresh_m) begin
                checkOutput("reset_operands", {alu_op, alu_rs1 | alu_rs2 | alu_imm}, 64'd0);
                checkOutput("reset_result", rsp0_result | rsp1_result, 64'd0);
            end
            if (phase < 0 && exp_g != 2'b00 && !rst) begin
                prev_acc       = 1'b1;
                prev_acc_owner = exp_g[1];
                e.owner = exp_g[1];
                e.op    = exp_g[1] ? req1_op  : req0_op;
                e.rs1   = exp_g[1] ? req1_rs1 : req0_rs1;
                e.rs2   = exp_g[1] ? req1_rs2 : req0_rs2;
                e.imm   = exp_g[1] ? req1_imm : req0_imm;
                e.res   = alu_ref(e.op, e.rs1, e.rs2, e.imm);
                sb.push_back(e);
            end
            prev_rsp_hs = (phase >= ALU_LAT + 2) && (owner_m ? rsp1_ready : rsp0_ready);
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    logic hs0, hs1;

    task automatic step();
        @(negedge clk);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic which, input logic v, input logic [4:0] op,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] imm);
        if (which) begin
            req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_imm = imm;
        end else begin
            req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_imm = imm;
        end
    endtask

    task automatic applyRandom(input logic which, input logic v);
        applyStimulus(which, v, 5'($urandom_range(16, 0)), $urandom, $urandom, $urandom);
    endtask

    task automatic issue(input logic which, input logic [4:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm);
        int   cyc = 0;
        logic got = 1'b0;
        applyStimulus(which, 1'b1, op, a, b, imm);
        while (!got && cyc < 60) begin
            step();
            cyc++;
            got = which ? hs1 : hs0;
        end
        applyStimulus(which, 1'b0, op, a, b, imm);
        checkOutput("accept_in_time", got, 1'b1);
    endtask

    task automatic drain();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (ALU_LAT + 5) step();
    endtask

    initial begin
        int   n_grants;
        int   n1;
        int   cyc;
        logic got;

        rst = 1'b1;
        hs0 = 1'b0; hs1 = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 5'd0, '0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed ADD on requester 0.
        issue(1'b0, ALU_ADD, 32'h0943_9AD4, 32'h0053_1794, 32'h0);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            if (rsp0_valid) got = 1'b1; else begin step(); cyc++; end
        end
        checkOutput("t1_rsp_seen", got, 1'b1);
        checkOutput("t1_result", rsp0_result, 32'h0996_B268);
        checkOutput("t1_latency", cyc, ALU_LAT + 1);
        drain();

        // Load/store address add on requester 1.
        issue(1'b1, ALU_LSU_ADD, 32'd3, 32'd0, 32'd4);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            if (rsp1_valid) got = 1'b1; else begin step(); cyc++; end
        end
        checkOutput("t2_rsp_seen", got, 1'b1);
        checkOutput("t2_result", rsp1_result, 32'd7);
        drain();

        // Both requesters held valid through eight grants.
        applyRandom(1'b0, 1'b1);
        applyRandom(1'b1, 1'b1);
        n_grants = 0; n1 = 0; cyc = 0;
        while (n_grants < 8 && cyc < 200) begin
            step();
            cyc++;
            if (hs0) begin n_grants++; applyRandom(1'b0, 1'b1); end
            if (hs1) begin n_grants++; n1++; applyRandom(1'b1, 1'b1); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("t3_grants", n_grants, 8);
`ifdef CORE_ALU_ARB_RR_EN
        checkOutput("t3_req1_grants", n1, 4);
`else
        checkOutput("t3_req1_grants", n1, 0);
`endif
        drain();

        // Response back-pressure for five cycles with requester 1 waiting.
        rsp0_ready = 1'b0;
        issue(1'b0, ALU_XOR, $urandom, $urandom, $urandom);
        applyRandom(1'b1, 1'b1);
        repeat (ALU_LAT + 1 + 5) step();
        rsp0_ready = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 30) begin
            step();
            cyc++;
            got = hs1;
        end
        req1_valid = 1'b0;
        checkOutput("t4_req1_accepted", got, 1'b1);
        drain();

        // Reset while waiting on the ALU, then a normal operation.
        issue(1'b0, ALU_SUB, $urandom, $urandom, $urandom);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (ALU_LAT + 3) step();
        issue(1'b0, ALU_OR, $urandom, $urandom, $urandom);
        drain();

        // Requester changes its operands right after acceptance.
        issue(1'b0, ALU_SLL, 32'h1234_5678, 32'd4, 32'h0);
        repeat (ALU_LAT + 2) begin
            applyRandom(1'b0, 1'b0);
            step();
        end
        drain();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 300; c++) begin
            step();
            if (hs0 || !req0_valid) applyRandom(1'b0, 1'($urandom_range(1, 0)));
            if (hs1 || !req1_valid) applyRandom(1'b1, 1'($urandom_range(1, 0)));
            rsp0_ready = ($urandom_range(9, 0) < 7);
            rsp1_ready = ($urandom_range(9, 0) < 7);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/core_alu_arb.md
# core_alu_arb

Two-requester arbiter and sequencer for the shared, clocked `core_alu` in the execute stage. Requester 0 is the integer-execute path (OP/OP-IMM/branch compare) and requester 1 is load/store address generation. The block accepts one operation at a time over a valid/ready handshake and drives the ALU with stable operands and a one-cycle start pulse. It waits the fixed ALU latency, then returns the captured result to the owning requester over a second valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `OP_W`, 5, width of the ALU op code (`alu_op_t`).
- `ALU_LAT`, 2, cycles from `alu_start` to a valid `alu_result`; must be ≥1, and 0 is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  OP_W  ALU operation.
- `req0_rs1`, `req0_rs2`, `req0_imm` / `req1_*`  in  XLEN  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp0_result` / `rsp1_result`  out  XLEN  result, driven from a shared result register.
- `alu_start`  out  1  one-cycle issue pulse to the ALU.
- `alu_op`  out  OP_W; `alu_rs1`, `alu_rs2`, `alu_imm`  out  XLEN  held ALU operands.
- `alu_result`  in  XLEN  ALU output.

## Operation
- State machine states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either `reqN_valid` is high, grant one requester according to policy (see Configuration).
  - `reqN_ready` is combinational: high only in IDLE, and only for the granted requester.
  - On the handshake, latch op, operands and owner id; next state is ISSUE.
- ISSUE: `alu_start`=1 for exactly this cycle; the counter is loaded with 0; next state is WAIT.
- WAIT:
  - The counter increments each cycle.
  - When counter == ALU_LAT-1, capture `alu_result` into the result register; next state is RESP.
- RESP:
  - `rspN_valid`=1 for the owner only; the result is held stable.
  - When `rspN_ready` is high, the handshake completes; next state is IDLE and the arbitration pointer is updated.
  - While in RESP, `rspN_valid` never deasserts without a handshake.
- `alu_op`, `alu_rs1`, `alu_rs2` and `alu_imm` come from the latch registers and are constant from ISSUE through capture.
- Only one operation is outstanding at a time. Both `reqN_ready` are 0 in ISSUE, WAIT and RESP.
- Unselected `rspM_result` carries the same register value. Consumers qualify it with `rspM_valid`.
- No arithmetic is done here. The counter is `$clog2(ALU_LAT+1)` bits wide and does not wrap within a transaction.
- Reset values: state IDLE; `req*_ready`, `rsp*_valid` and `alu_start` are 0; latch registers and result are 0; the RR pointer favours req0.
- Reset mid-operation: the transaction is abandoned and no response is produced. A late `alu_result` is ignored.

## Timing
- Accept at cycle 0 → `alu_start` at cycle 1 → result captured at the end of cycle ALU_LAT+1 → `rspN_valid` from cycle ALU_LAT+2.
- With `rspN_ready` held high, IDLE is re-entered at cycle ALU_LAT+3. Peak throughput is therefore one operation per ALU_LAT+3 cycles.
- Simultaneous valid on both requesters is resolved in the same cycle; exactly one ready is asserted.
- A request that arrives while the block is busy waits with its valid held and is arbitrated on IDLE re-entry.

## Configuration
- `CORE_ALU_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - The pointer flips to the non-owner after each completed response handshake.
  - Under ties the pointed-to requester wins.
- `CORE_ALU_ARB_RR_EN` undefined:
  - Fixed priority; req0 always wins ties.
  - The pointer register is not built.

## Structure
- Package `core_alu_pkg` holds:
  - `alu_op_t` (5-bit enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, the branch-compare ops, and LSU address add).
  - `arb_state_t`.
  - The `XLEN` default.
- Sub-module `core_alu_arb_grant` holds the 2-way grant logic and the optional RR pointer, selected by the macro.
- The FSM, latches and counter live in the top module.

## Test plan
- ALU_LAT=2; req0 ADD with rs1=0x0943_9AD4, rs2=0x0053_1794, and the ALU model returns the sum → `alu_start` at cycle 1, `rsp0_valid` at cycle 4, `rsp0_result`=0x0996_B268, `rsp1_valid` stays 0.
- req1 LSU add with rs1=3, imm=4 → `rsp1_result`=7; exactly one `alu_start` pulse is seen.
- req0 and req1 held valid continuously:
  - With RR: grants alternate 0,1,0,1.
  - Without RR: req0 wins every grant and req1 never receives ready.
- `rsp0_ready` held low for 5 cycles → `rsp0_valid` and result stay constant, `req1_ready` stays 0, no further `alu_start`.
- `rst` asserted in WAIT → next cycle all outputs are 0 and no response is produced; a new req0 afterwards completes with normal latency.
- Operand stability: `req0_rs1` changes after accept → `alu_rs1` stays at the latched value until capture.
